// File: rtl/core_issue_scoreboard.sv
// Register scoreboard and issue controller between decode and execute.
// Tracks pending writes per architectural register and in total, holds back
// issue on RAW/WAW hazards or occupancy limits, and drains after a flush.
module core_issue_scoreboard #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_used,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       de_ready,
  output logic       issue_ok,
  output logic       issue_fire,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       flush_en,
  output logic       draining,
  output logic [3:0] inflight_cnt,
  output logic       sb_err
);

  localparam logic [CNT_W-1:0] PendMax     = '1;
  localparam logic [3:0]       MaxInflight = 4'(MAX_INFLIGHT);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic [3:0]       inflight_q, inflight_d;
  logic             err_q, err_d;

  logic rs1_haz, rs2_haz, rd_write, rd_block, inc, dec;

  // Issue decision from registered state only; wb_valid is never bypassed.
  always_comb begin
    rs1_haz    = id_rs1_used && (id_rs1 != 5'd0) && (pend_q[id_rs1] != '0);
    rs2_haz    = id_rs2_used && (id_rs2 != 5'd0) && (pend_q[id_rs2] != '0);
    rd_write   = id_reg_write && (id_rd != 5'd0);
    rd_block   = rd_write && ((pend_q[id_rd] == PendMax) || (inflight_q >= MaxInflight));
    issue_ok   = (state_q == StRun) && !flush_en && !rs1_haz && !rs2_haz && !rd_block;
    issue_fire = id_valid && issue_ok && de_ready;
    inc        = issue_fire && rd_write;
    dec        = wb_valid && (wb_rd != 5'd0);
  end

  // Per-register and total counter updates; underflow sets the sticky error.
  always_comb begin
    pend_d     = pend_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    // Matching inc/dec on one register cancel out.
    if (!(inc && dec && (id_rd == wb_rd))) begin
      if (inc) begin
        pend_d[id_rd] = pend_q[id_rd] + 1'b1;
      end
      if (dec) begin
        if (pend_q[wb_rd] == '0) begin
          err_d = 1'b1;
        end else begin
          pend_d[wb_rd] = pend_q[wb_rd] - 1'b1;
        end
      end
    end
    if (inc && !dec) begin
      inflight_d = inflight_q + 4'd1;
    end else if (dec && !inc) begin
      if (inflight_q == 4'd0) begin
        err_d = 1'b1;
      end else begin
        inflight_d = inflight_q - 4'd1;
      end
    end
  end

  // RUN/DRAIN sequencing around flushes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (flush_en && (inflight_d != 4'd0)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave once the registered count shows everything has reported back.
        if (!flush_en && (inflight_q == 4'd0)) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q    <= StRun;
      pend_q     <= '{default: '0};
      inflight_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign draining     = (state_q == StDrain);
  assign inflight_cnt = inflight_q;
  assign sb_err       = err_q;

endmodule
